// File: rtl/spi_port_regs.sv
`timescale 1ns/1ps
// SPI mode-0 slave register bank: NUM_PORTS output channels, NUM_PORTS input samples and an ID byte.
// Define SPI_PORT_REGS_SYNC2_EN for two-flop input synchronisers; default is a single register stage.
module spi_port_regs #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W = 8,
  parameter logic [PORT_W-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          spi_cs_n,
  input  logic                          spi_sclk,
  input  logic                          spi_mosi,
  output logic                          spi_miso,
  output logic                          spi_miso_oe,
  input  logic [NUM_PORTS*PORT_W-1:0]   port_i,
  output logic [NUM_PORTS*PORT_W-1:0]   port_o,
  output logic [NUM_PORTS-1:0]          wr_strobe
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

  state_t      state, state_nxt;
  logic        cs_s, sclk_s, mosi_s, sclk_q;
  logic        sclk_rise, sclk_fall;
  logic [3:0]  cnt;
  logic [6:0]  sr;
  logic        wr_q;
  logic [6:0]  addr_q;
  logic [6:0]  addr_nxt;
  logic [7:0]  data_in;
  logic [7:0]  rd_val;
  logic [7:0]  snap;
  logic        miso_q;
  logic        wr_pend;
  logic [3:0]  wr_idx;
  logic [PORT_W-1:0] wr_dat;
  logic        shift_en, snap_en, miso_en, commit_en;

`ifdef SPI_PORT_REGS_SYNC2_EN
  logic cs_m, sclk_m, mosi_m;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_m   <= 1'b1;
      sclk_m <= 1'b0;
      mosi_m <= 1'b0;
      cs_s   <= 1'b1;
      sclk_s <= 1'b0;
      mosi_s <= 1'b0;
    end else begin
      cs_m   <= spi_cs_n;
      sclk_m <= spi_sclk;
      mosi_m <= spi_mosi;
      cs_s   <= cs_m;
      sclk_s <= sclk_m;
      mosi_s <= mosi_m;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s   <= 1'b1;
      sclk_s <= 1'b0;
      mosi_s <= 1'b0;
    end else begin
      cs_s   <= spi_cs_n;
      sclk_s <= spi_sclk;
      mosi_s <= spi_mosi;
    end
  end
`endif

  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign addr_nxt  = {sr[5:0], mosi_s};
  assign data_in   = {sr, mosi_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // CS deassertion wins over any SCLK edge seen in the same cycle, so a late CS rise aborts the commit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!cs_s) state_nxt = HDR;
      HDR: begin
        if (cs_s)                             state_nxt = IDLE;
        else if (sclk_rise && cnt == 4'd7)    state_nxt = DATA;
      end
      DATA: begin
        if (cs_s)                             state_nxt = IDLE;
        else if (sclk_rise && cnt == 4'd15)   state_nxt = DONE;
      end
      DONE: if (cs_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    spi_miso_oe = ~cs_s;
    spi_miso    = miso_q & ~cs_s;
    shift_en    = sclk_rise && !cs_s && (state == HDR || state == DATA);
    snap_en     = (state == HDR) && (state_nxt == DATA);
    miso_en     = sclk_fall && !cs_s && (state == DATA);
    commit_en   = (state == DATA) && (state_nxt == DONE) && wr_q && (addr_q < 7'(NUM_PORTS));
  end

  always_comb begin
    rd_val = 8'h00;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (addr_nxt == 7'(k))      rd_val = 8'(port_o[k*PORT_W +: PORT_W]);
      if (addr_nxt == 7'(16 + k)) rd_val = 8'(port_i[k*PORT_W +: PORT_W]);
    end
    if (addr_nxt == 7'h7F) rd_val = {4'hA, 4'(NUM_PORTS - 1)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q  <= 1'b0;
      cnt     <= 4'd0;
      sr      <= 7'd0;
      wr_q    <= 1'b0;
      addr_q  <= 7'd0;
      snap    <= 8'd0;
      miso_q  <= 1'b0;
      wr_pend <= 1'b0;
      wr_idx  <= 4'd0;
      wr_dat  <= '0;
    end else begin
      sclk_q  <= sclk_s;
      wr_pend <= commit_en;
      if (state == IDLE) begin
        cnt    <= 4'd0;
        sr     <= 7'd0;
        miso_q <= 1'b0;
      end
      if (shift_en) begin
        cnt <= cnt + 4'd1;
        sr  <= {sr[5:0], mosi_s};
      end
      if (snap_en) begin
        wr_q   <= sr[6];
        addr_q <= addr_nxt;
        snap   <= rd_val;
      end
      if (miso_en) begin
        miso_q <= snap[7];
        snap   <= {snap[6:0], 1'b0};
      end
      if (commit_en) begin
        wr_idx <= addr_q[3:0];
        wr_dat <= data_in[PORT_W-1:0];
      end
    end
  end

  // Commit is registered one cycle after the last-bit decision to give a fixed S+1 write latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_o    <= {NUM_PORTS{RESET_VAL}};
      wr_strobe <= '0;
    end else begin
      wr_strobe <= '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (wr_pend && wr_idx == 4'(k)) begin
          port_o[k*PORT_W +: PORT_W] <= wr_dat;
          wr_strobe[k]               <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_port_regs.sv
`timescale 1ns/1ps
// Directed bench for spi_port_regs: an 8-bit-wide and a 4-bit-wide instance share one SPI master.
module tb_spi_port_regs;
`ifdef SPI_PORT_REGS_SYNC2_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif

  logic clk = 1'b0, rst_n = 1'b0, cs_n = 1'b1, sclk = 1'b0, mosi = 1'b0;
  logic miso, miso_oe, miso4, miso_oe4;
  logic [31:0] port_i = 32'h0000C396;
  logic [31:0] port_o;
  logic [3:0]  wr_strobe;
  logic [15:0] port_i4 = 16'h0000;
  logic [15:0] port_o4;
  logic [3:0]  wr_strobe4;

  int compared = 0, mismatched = 0;
  logic [7:0] rx, rx4;
  logic hdr_bad, oe_bad;
  int stb_first, stb_hits, stb_pulses = 0;
  logic [3:0] stb_val;
  logic [31:0] po_pre, po_post;

  spi_port_regs #(.NUM_PORTS(4), .PORT_W(8), .RESET_VAL(8'h3C)) dut (
    .clk(clk), .rst_n(rst_n), .spi_cs_n(cs_n), .spi_sclk(sclk), .spi_mosi(mosi),
    .spi_miso(miso), .spi_miso_oe(miso_oe), .port_i(port_i), .port_o(port_o), .wr_strobe(wr_strobe));

  spi_port_regs #(.NUM_PORTS(4), .PORT_W(4), .RESET_VAL(4'h5)) dut4 (
    .clk(clk), .rst_n(rst_n), .spi_cs_n(cs_n), .spi_sclk(sclk), .spi_mosi(mosi),
    .spi_miso(miso4), .spi_miso_oe(miso_oe4), .port_i(port_i4), .port_o(port_o4), .wr_strobe(wr_strobe4));

  always #5 clk = ~clk;
  always @(posedge clk) if (wr_strobe !== 4'b0 || wr_strobe4 !== 4'b0) stb_pulses++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // SCLK half period is 4 clk cycles; CS setup/hold are 8 cycles.
  task automatic spi_xfer(input logic [15:0] frame, input int nbits, input bit raise_cs);
    rx = 8'h00; rx4 = 8'h00; hdr_bad = 1'b0; oe_bad = 1'b0;
    stb_first = 0; stb_hits = 0; stb_val = 4'h0; po_pre = '0; po_post = '0;
    @(negedge clk);
    cs_n = 1'b0;
    wait_neg(8);
    for (int i = 0; i < nbits; i++) begin
      mosi = frame[15-i];
      wait_neg(4);
      if (miso_oe !== 1'b1 || miso_oe4 !== 1'b1) oe_bad = 1'b1;
      if (i >= 8) begin
        rx  = {rx[6:0], miso};
        rx4 = {rx4[6:0], miso4};
      end else if (miso !== 1'b0 || miso4 !== 1'b0) hdr_bad = 1'b1;
      sclk = 1'b1;
      if (i == 15) begin
        for (int c = 1; c <= 8; c++) begin
          @(posedge clk); #1;
          if (c == S + 1) po_pre = port_o;
          if (c == S + 2) po_post = port_o;
          if (wr_strobe !== 4'b0) begin
            stb_hits++;
            if (stb_first == 0) begin stb_first = c; stb_val = wr_strobe; end
          end
        end
        @(negedge clk);
      end else wait_neg(4);
      sclk = 1'b0;
    end
    wait_neg(8);
    if (raise_cs) begin
      cs_n = 1'b1;
      wait_neg(8);
    end
  endtask

  task automatic test_reset();
    wait_neg(3);
    compared++; if (port_o !== 32'h3C3C3C3C) begin mismatched++; $display("FAIL reset_port_o: got %h want 3c3c3c3c", port_o); end
    compared++; if (port_o4 !== 16'h5555) begin mismatched++; $display("FAIL reset_port_o4: got %h want 5555", port_o4); end
    compared++; if (wr_strobe !== 4'b0) begin mismatched++; $display("FAIL reset_strobe: got %b want 0000", wr_strobe); end
    compared++; if ({miso, miso_oe} !== 2'b00) begin mismatched++; $display("FAIL reset_miso: got miso/oe %b want 00", {miso, miso_oe}); end
    rst_n = 1'b1;
    wait_neg(6);
    compared++; if ({miso, miso_oe, port_o} !== {2'b00, 32'h3C3C3C3C}) begin mismatched++; $display("FAIL post_reset_idle: got %h", {miso, miso_oe, port_o}); end
  endtask

  task automatic test_write();
    spi_xfer(16'h825A, 16, 1'b1);
    compared++; if (stb_first !== S + 2) begin mismatched++; $display("FAIL wr_latency: strobe at cycle %0d want %0d", stb_first, S + 2); end
    compared++; if (stb_hits !== 1) begin mismatched++; $display("FAIL wr_strobe_width: got %0d cycles want 1", stb_hits); end
    compared++; if (stb_val !== 4'b0100) begin mismatched++; $display("FAIL wr_strobe_val: got %b want 0100", stb_val); end
    compared++; if ({po_pre[23:16], po_post[23:16]} !== 16'h3C5A) begin mismatched++; $display("FAIL wr_update_edge: pre/post %h want 3c5a", {po_pre[23:16], po_post[23:16]}); end
    compared++; if (port_o !== 32'h3C5A3C3C) begin mismatched++; $display("FAIL wr_port_o: got %h want 3c5a3c3c", port_o); end
    compared++; if (port_o4 !== 16'h5A55) begin mismatched++; $display("FAIL wr_port_o4: got %h want 5a55", port_o4); end
    compared++; if (rx !== 8'h3C) begin mismatched++; $display("FAIL wr_miso_old: got %h want 3c", rx); end
  endtask

  task automatic test_read_port_i();
    int base;
    base = stb_pulses;
    spi_xfer(16'h1100, 16, 1'b1);
    compared++; if (rx !== 8'hC3) begin mismatched++; $display("FAIL rd_port_i: got %h want c3", rx); end
    compared++; if (hdr_bad !== 1'b0) begin mismatched++; $display("FAIL rd_hdr_zero: got %b want 0", hdr_bad); end
    compared++; if (oe_bad !== 1'b0) begin mismatched++; $display("FAIL rd_oe_active: got %b want 0", oe_bad); end
    compared++; if ({miso_oe, miso} !== 2'b00) begin mismatched++; $display("FAIL rd_oe_after_cs: got %b want 00", {miso_oe, miso}); end
    compared++; if (stb_pulses - base !== 0) begin mismatched++; $display("FAIL rd_no_strobe: got %0d pulses want 0", stb_pulses - base); end
  endtask

  task automatic test_id_unmapped();
    int base;
    spi_xfer(16'h7F00, 16, 1'b1);
    compared++; if ({rx, rx4} !== 16'hA3A3) begin mismatched++; $display("FAIL id_read: got %h want a3a3", {rx, rx4}); end
    spi_xfer(16'h4000, 16, 1'b1);
    compared++; if (rx !== 8'h00) begin mismatched++; $display("FAIL unmapped_read: got %h want 00", rx); end
    base = stb_pulses;
    spi_xfer(16'h90FF, 16, 1'b1);
    compared++; if (rx !== 8'h96) begin mismatched++; $display("FAIL ro_write_rx: got %h want 96", rx); end
    compared++; if (port_o !== 32'h3C5A3C3C) begin mismatched++; $display("FAIL ro_write_port_o: got %h want 3c5a3c3c", port_o); end
    compared++; if (stb_pulses - base !== 0) begin mismatched++; $display("FAIL ro_write_strobe: got %0d pulses want 0", stb_pulses - base); end
  endtask

  task automatic test_abort();
    int base;
    base = stb_pulses;
    spi_xfer(16'h8177, 12, 1'b1);
    wait_neg(8);
    compared++; if (port_o !== 32'h3C5A3C3C) begin mismatched++; $display("FAIL abort_port_o: got %h want 3c5a3c3c", port_o); end
    compared++; if (stb_pulses - base !== 0) begin mismatched++; $display("FAIL abort_strobe: got %0d pulses want 0", stb_pulses - base); end
    spi_xfer(16'h8177, 16, 1'b1);
    compared++; if (port_o !== 32'h3C5A773C) begin mismatched++; $display("FAIL after_abort_port_o: got %h want 3c5a773c", port_o); end
    compared++; if ({stb_val, 4'(stb_hits)} !== 8'h21) begin mismatched++; $display("FAIL after_abort_strobe: got %b x%0d want 0010 x1", stb_val, stb_hits); end
    compared++; if (port_o4 !== 16'h5A75) begin mismatched++; $display("FAIL after_abort_port_o4: got %h want 5a75", port_o4); end
  endtask

  task automatic test_port_w4();
    spi_xfer(16'h80AB, 16, 1'b1);
    compared++; if (port_o4 !== 16'h5A7B) begin mismatched++; $display("FAIL w4_port_o4: got %h want 5a7b", port_o4); end
    compared++; if (rx4 !== 8'h05) begin mismatched++; $display("FAIL w4_miso_old: got %h want 05", rx4); end
    spi_xfer(16'h0000, 16, 1'b1);
    compared++; if (rx4 !== 8'h0B) begin mismatched++; $display("FAIL w4_readback: got %h want 0b", rx4); end
    compared++; if (rx !== 8'hAB) begin mismatched++; $display("FAIL w8_readback: got %h want ab", rx); end
  endtask

  task automatic test_reset_midwrite();
    int base;
    base = stb_pulses;
    spi_xfer(16'h8366, 14, 1'b0);
    rst_n = 1'b0;
    wait_neg(2);
    compared++; if (port_o !== 32'h3C3C3C3C) begin mismatched++; $display("FAIL midrst_port_o: got %h want 3c3c3c3c", port_o); end
    compared++; if (port_o4 !== 16'h5555) begin mismatched++; $display("FAIL midrst_port_o4: got %h want 5555", port_o4); end
    compared++; if ({wr_strobe, miso, miso_oe} !== 6'b0) begin mismatched++; $display("FAIL midrst_outputs: got %b want 000000", {wr_strobe, miso, miso_oe}); end
    cs_n = 1'b1;
    wait_neg(8);
    rst_n = 1'b1;
    wait_neg(40);
    compared++; if (port_o !== 32'h3C3C3C3C) begin mismatched++; $display("FAIL midrst_no_commit: got %h want 3c3c3c3c", port_o); end
    compared++; if (stb_pulses - base !== 0) begin mismatched++; $display("FAIL midrst_strobe: got %0d pulses want 0", stb_pulses - base); end
    spi_xfer(16'h0300, 16, 1'b1);
    compared++; if (rx !== 8'h3C) begin mismatched++; $display("FAIL midrst_next_frame: got %h want 3c", rx); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_port_i();
    test_id_unmapped();
    test_abort();
    test_port_w4();
    test_reset_midwrite();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_port_regs.md
# spi_port_regs

Parametrised SPI slave register bank that drives and samples the mixed-signal port channels of the Tiny Tapeout top level. An external master on the bidirectional PMOD uses 16-bit frames to write NUM_PORTS output port registers and read back NUM_PORTS input port samples. The block oversamples the SPI pins in the system clock domain. It is the generalised successor to the fixed single 8-bit `port_i`/`port_o` pair: the channel count and width are configurable, and each channel has a per-channel write strobe.

## Interface
Parameters:
- NUM_PORTS, 4, number of port channels (1..16)
- PORT_W, 8, width of each channel (1..8)
- RESET_VAL, 0, reset value of every `port_o` channel (PORT_W bits)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- spi_cs_n  input  1  chip select, active low
- spi_sclk  input  1  SPI clock, mode 0 (idle low)
- spi_mosi  input  1  master data out
- spi_miso  output  1  slave data out
- spi_miso_oe  output  1  MISO pad output enable, active high
- port_i  input  NUM_PORTS*PORT_W  input channels; channel k is bits [k*PORT_W +: PORT_W]
- port_o  output  NUM_PORTS*PORT_W  output channel registers
- wr_strobe  output  NUM_PORTS  one-cycle pulse when channel k is written

## Operation
- Frame format, MSB first, 16 bits: bit15 is W (1 = write, 0 = read), bits14:8 are ADDR[6:0], bits7:0 are DATA.
- MOSI is sampled on the rising SCLK edge. MISO changes on the falling SCLK edge.
- Address map:
  - 0x00..NUM_PORTS-1: `port_o` channels, read/write.
  - 0x10..0x10+NUM_PORTS-1: `port_i` channels, read-only.
  - 0x7F: ID, read-only, value {4'hA, NUM_PORTS-1 [3:0]}.
  - Any other address: reads return 0x00, writes are ignored.
  - Writes to read-only addresses are ignored; no strobe is issued.
- Writes store DATA[PORT_W-1:0]. Reads return the value zero-extended to 8 bits.
- FSM states:
  - IDLE: CS high.
  - HDR: bits 15..8.
  - DATA: bits 7..0.
  - DONE: after bit 0, until CS rises.
- FSM transitions:
  - IDLE to HDR on the CS falling edge. The bit counter clears.
  - HDR to DATA on the 8th rising SCLK. The target value is snapshotted into the MISO shift register here; a `port_i` read is sampled on this cycle.
  - DATA to DONE on the 16th rising SCLK. A write commits here if W=1 and the address is writable.
  - DONE: further SCLK edges are ignored, with no burst and no second frame until CS goes high and then low again.
- MISO:
  - Drives 0 during HDR.
  - Drives the snapshot MSB at the first falling SCLK in DATA, then the following bits, MSB first.
  - For W=1 frames, MISO still returns the current register value.
- `spi_miso_oe` = synchronised CS active. `spi_miso` = 0 whenever `spi_miso_oe` = 0.
- CS rising in any state returns the FSM to IDLE. An incomplete frame has no effect.
- Reset, including mid-frame: FSM goes to IDLE, counter = 0, `port_o` = RESET_VAL on every channel, `wr_strobe` = 0, `spi_miso` = 0, `spi_miso_oe` = 0. Any partial frame is discarded.

## Timing
- The three SPI inputs pass through S synchroniser flops (S = 2 or 1; see Configuration). SCLK edges are detected on the synchronised signal.
- Requirement: clk frequency ≥ 4 × SCLK frequency. CS setup to the first SCLK and hold after the last SCLK are each ≥ 2 SCLK half-periods.
- Write commit: `port_o[k]` updates and `wr_strobe[k]` is high for exactly 1 cycle. Both happen S+1 clk cycles after the first clk edge that samples the 16th SCLK high at the pin.
- A CS rise synchronised on the same cycle as the 16th edge detection is an abort: no commit.
- `port_i` has no internal synchroniser beyond the read snapshot register.

## Configuration
- Macro SPI_PORT_REGS_SYNC2_EN.
- Defined: S = 2 (two-flop synchronisers on CS, SCLK and MOSI). Write latency is 3 cycles.
- Undefined: S = 1 (single register stage, for boards with clean SPI sources). Write latency is 2 cycles. All other behaviour is identical.

## Test plan
- Reset release, then write frame 0x82 0x5A (W=1, ADDR 0x02): `port_o` channel 2 = 0x5A, `wr_strobe` = 4'b0100 for 1 cycle, other channels stay at RESET_VAL.
- `port_i` channel 1 = 0xC3, then read frame 0x11 0x00: MISO bits 7..0 = 0xC3, MISO = 0 during the header, `spi_miso_oe` high only while CS is low.
- Read 0x7F with NUM_PORTS=4: returns 0xA3. Read 0x40: returns 0x00. Write 0x90 0xFF (read-only address): no `port_o` change, no strobe.
- Write 0x81 0x77 with CS released after 12 bits: channel 1 unchanged, no strobe. The next full frame then works normally.
- PORT_W=4: write 0x80 0xAB gives `port_o` channel 0 = 0xB. Read-back of address 0x00 returns 0x0B.
- Assert `rst_n` low mid-write after 14 bits: all outputs return to reset values. No commit occurs after the reset is released.
